uart_tx_framer: RTL

UART_TX_FRAMER -- requirements
Module: uart_tx_framer

---
 rtl/uart_tx_framer.sv | 138 +++++++++++++
 1 files changed

// File: rtl/uart_tx_framer.sv
// rtl/uart_tx_framer.sv - UART transmit framer: start, 8 data bits LSB first, optional parity, stop
module uart_tx_framer #(
  parameter int PRESCALE = 1
) (
  input  logic       TX_CLK,
  input  logic       RST,
  input  logic [7:0] P_DATA,
  input  logic       DATA_VALID,
  input  logic       PAR_EN,
  input  logic       PAR_TYP,
  output logic       TX_OUT,
  output logic       BUSY
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  localparam logic [4:0] CNT_LAST = 5'(PRESCALE - 1);

  state_t     state_q, state_n;
  logic [4:0] cnt_q, cnt_n;
  logic [2:0] idx_q, idx_n;
  logic [2:0] idx_inc;
  logic [7:0] data_q;
  logic       par_en_q, par_typ_q;
  logic       tx_q, tx_n;
  logic       busy_q, busy_n;
  logic       accept;
  logic       cnt_last;
  logic       parity_bit;

  assign idx_inc    = idx_q + 3'd1;
  assign cnt_last   = (cnt_q == CNT_LAST);
  assign parity_bit = (^data_q) ^ par_typ_q;

  // tx_n/busy_n describe the line level for the state being entered, so the
  // registered outputs line up with the state register without extra latency.
  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q + 5'd1;
    idx_n   = idx_q;
    tx_n    = 1'b1;
    busy_n  = 1'b1;
    accept  = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_n  = 5'd0;
        busy_n = 1'b0;
        if (DATA_VALID) begin
          accept  = 1'b1;
          state_n = START;
          busy_n  = 1'b1;
          tx_n    = 1'b0;
        end
      end
      START: begin
        tx_n = 1'b0;
        if (cnt_last) begin
          cnt_n   = 5'd0;
          idx_n   = 3'd0;
          state_n = DATA;
          tx_n    = data_q[0];
        end
      end
      DATA: begin
        tx_n = data_q[idx_q];
        if (cnt_last) begin
          cnt_n = 5'd0;
          if (idx_q == 3'd7) begin
            if (par_en_q) begin
              state_n = PARITY;
              tx_n    = parity_bit;
            end else begin
              state_n = STOP;
              tx_n    = 1'b1;
            end
          end else begin
            idx_n = idx_inc;
            tx_n  = data_q[idx_inc];
          end
        end
      end
      PARITY: begin
        tx_n = parity_bit;
        if (cnt_last) begin
          cnt_n   = 5'd0;
          state_n = STOP;
          tx_n    = 1'b1;
        end
      end
      STOP: begin
        if (cnt_last) begin
          cnt_n   = 5'd0;
          state_n = IDLE;
          busy_n  = 1'b0;
        end
      end
      default: begin
        cnt_n   = 5'd0;
        state_n = IDLE;
        busy_n  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge TX_CLK) begin
    if (RST) begin
      state_q   <= IDLE;
      cnt_q     <= 5'd0;
      idx_q     <= 3'd0;
      data_q    <= 8'd0;
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
      idx_q   <= idx_n;
      tx_q    <= tx_n;
      busy_q  <= busy_n;
      if (accept) begin
        data_q    <= P_DATA;
        par_en_q  <= PAR_EN;
        par_typ_q <= PAR_TYP;
      end
    end
  end

  assign TX_OUT = tx_q;
  assign BUSY   = busy_q;

endmodule
